// File: rtl/raw_hazard_scoreboard_if.sv
// ============================================================================
// Module : raw_hazard_scoreboard_if
// Brief  : Issue and writeback handshake bundle for the RAW hazard scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface raw_hazard_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic [4:0] issue_rd;
  logic       issue_rd_we;
  logic       issue_ready;
  logic       rs1_busy;
  logic       rs2_busy;
  logic       wb_valid;
  logic [4:0] wb_rd;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
    output wb_valid, wb_rd,
    input  issue_ready, rs1_busy, rs2_busy
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
    input  wb_valid, wb_rd,
    output issue_ready, rs1_busy, rs2_busy
  );
endinterface

`default_nettype wire

// File: rtl/raw_hazard_scoreboard.sv
// ============================================================================
// Module : raw_hazard_scoreboard
// Brief  : Tracks in-flight register writes and stalls issue on unresolved RAW,
//          WAW-counter saturation or the global in-flight cap.
//          Optional stall counter enabled by SCOREBOARD_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module raw_hazard_scoreboard #(
  parameter int XLEN         = 32,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 2
) (
  input  wire logic                              i_clk,
  input  wire logic                              i_rst,
  input  wire logic                              i_flush,
  raw_hazard_scoreboard_if.slave                 sb,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]      o_inflight_cnt,
  output logic                                   o_full,
  output logic [XLEN-1:0]                        o_stall_cycles
);

  localparam int               c_IW       = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] c_PEND_MAX = {CNT_W{1'b1}};
  localparam logic [c_IW-1:0]  c_CAP      = c_IW'(MAX_INFLIGHT);

  logic [31:0][CNT_W-1:0] pend_q, pend_d;
  logic [c_IW-1:0]        inflight_q, inflight_d;

  logic [CNT_W-1:0] w_pend_rs1, w_pend_rs2, w_pend_rd, w_pend_wb;
  logic             w_rs1_raw, w_rs2_raw, w_waw_full, w_cap_full;
  logic             w_ready, w_inc, w_dec, w_rd_tracked;

  // Entry 0 is never written, so x0 always reads as idle.
  assign w_pend_rs1 = pend_q[sb.issue_rs1];
  assign w_pend_rs2 = pend_q[sb.issue_rs2];
  assign w_pend_rd  = pend_q[sb.issue_rd];
  assign w_pend_wb  = pend_q[sb.wb_rd];

  // A retire against an empty counter is a protocol error and is dropped.
  assign w_dec        = sb.wb_valid && (sb.wb_rd != 5'd0) && (w_pend_wb != '0);
  assign w_rd_tracked = sb.issue_rd_we && (sb.issue_rd != 5'd0);

  // The sole pending write retiring this cycle is covered by forwarding.
  assign w_rs1_raw = (w_pend_rs1 > CNT_W'(1)) ||
                     ((w_pend_rs1 == CNT_W'(1)) && !(sb.wb_valid && sb.wb_rd == sb.issue_rs1));
  assign w_rs2_raw = (w_pend_rs2 > CNT_W'(1)) ||
                     ((w_pend_rs2 == CNT_W'(1)) && !(sb.wb_valid && sb.wb_rd == sb.issue_rs2));

  assign w_waw_full = w_rd_tracked && (w_pend_rd == c_PEND_MAX) &&
                      !(w_dec && sb.wb_rd == sb.issue_rd);
  assign w_cap_full = w_rd_tracked && (inflight_q == c_CAP) && !w_dec;

  assign w_ready = !w_rs1_raw && !w_rs2_raw && !w_waw_full && !w_cap_full && !i_flush;
  assign w_inc   = sb.issue_valid && w_ready && w_rd_tracked;

  assign sb.issue_ready = w_ready;
  assign sb.rs1_busy    = sb.issue_valid && w_rs1_raw;
  assign sb.rs2_busy    = sb.issue_valid && w_rs2_raw;

  always_comb begin
    pend_d     = pend_q;
    inflight_d = inflight_q;
    if (i_flush) begin
      pend_d     = '0;
      inflight_d = '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (w_inc && (sb.issue_rd == 5'(r)) && !(w_dec && (sb.wb_rd == 5'(r)))) begin
          pend_d[r] = pend_q[r] + CNT_W'(1);
        end else if (w_dec && (sb.wb_rd == 5'(r)) && !(w_inc && (sb.issue_rd == 5'(r)))) begin
          pend_d[r] = pend_q[r] - CNT_W'(1);
        end
      end
      inflight_d = inflight_q + c_IW'(w_inc) - c_IW'(w_dec);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q     <= '0;
      inflight_q <= '0;
    end else begin
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
    end
  end

  assign o_inflight_cnt = inflight_q;
  assign o_full         = (inflight_q == c_CAP);

`ifdef SCOREBOARD_STATS_EN
  logic [XLEN-1:0] stall_q, stall_d;

  // Saturating; flush intentionally leaves the count intact.
  always_comb begin
    stall_d = stall_q;
    if (sb.issue_valid && !w_ready && (stall_q != '1)) begin
      stall_d = stall_q + XLEN'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = '0;
`endif

`ifndef SYNTHESIS
  a_no_underflow : assert property (@(posedge i_clk) disable iff (i_rst)
    (sb.wb_valid && (sb.wb_rd != 5'd0) && !i_flush) |-> (w_pend_wb != '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_raw_hazard_scoreboard.sv
// ============================================================================
// Module : tb_raw_hazard_scoreboard
// Brief  : Table-driven checks of the RAW hazard scoreboard plus hand-written
//          reset and stall-counter sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_raw_hazard_scoreboard;

  localparam int XLEN = 32;
  localparam int MAXI = 8;
  localparam int IW   = $clog2(MAXI + 1);

  typedef struct {
    logic       fl;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic       wv;
    logic [4:0] wrd;
    logic       rdy;
    logic       b1;
    logic       b2;
    logic [IW-1:0] cnt;
    logic       full;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [IW-1:0]   inflight;
  logic            full;
  logic [XLEN-1:0] stall;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_stall;

  vec_t tbl[$];

  raw_hazard_scoreboard_if bus ();

  raw_hazard_scoreboard #(.XLEN(XLEN), .MAX_INFLIGHT(MAXI), .CNT_W(2)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .sb             (bus.slave),
    .o_inflight_cnt (inflight),
    .o_full         (full),
    .o_stall_cycles (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic we, input logic wv, input logic [4:0] wrd,
                     input logic rdy, input logic b1, input logic b2, input int cnt, input logic fu);
    vec_t e;
    e.fl = fl; e.v = v; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.we = we;
    e.wv = wv; e.wrd = wrd; e.rdy = rdy; e.b1 = b1; e.b2 = b2;
    e.cnt = IW'(cnt); e.full = fu;
    tbl.push_back(e);
  endtask

  task automatic drive_idle();
    flush = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.issue_rd = '0; bus.issue_rd_we = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0;
  endtask

  task automatic apply(input vec_t e, input string tag);
    @(negedge clk);
    flush = e.fl;
    bus.issue_valid = e.v; bus.issue_rs1 = e.rs1; bus.issue_rs2 = e.rs2;
    bus.issue_rd = e.rd; bus.issue_rd_we = e.we; bus.wb_valid = e.wv; bus.wb_rd = e.wrd;
    #1;
    chk({tag, " ready"}, 32'(bus.issue_ready), 32'(e.rdy));
    chk({tag, " rs1_busy"}, 32'(bus.rs1_busy), 32'(e.b1));
    chk({tag, " rs2_busy"}, 32'(bus.rs2_busy), 32'(e.b2));
    @(posedge clk);
    #1;
    chk({tag, " inflight"}, 32'(inflight), 32'(e.cnt));
    chk({tag, " full"}, 32'(full), 32'(e.full));
  endtask

  initial begin
    vec_t h;

    // fl v rs1 rs2 rd we wv wrd | rdy b1 b2 cnt full
    add(0,1, 0, 0, 5,1, 0,0,  1,0,0, 1,0);          // write x5
    add(0,1, 5, 0, 0,0, 0,0,  0,1,0, 1,0);          // RAW on x5
    add(0,1, 0, 5, 0,0, 1,5,  1,0,0, 0,0);          // bypass via same-cycle retire
    add(0,1, 5, 0, 0,0, 0,0,  1,0,0, 0,0);
    for (int i = 0; i < 8; i++) add(0,1, 0, 0, 0,1, 0,0,  1,0,0, 0,0); // x0 untracked
    for (int r = 1; r <= 8; r++) add(0,1, 0, 0, 5'(r),1, 0,0,  1,0,0, r, r == 8);
    add(0,1, 0, 0, 9,1, 0,0,  0,0,0, 8,1);          // cap reached
    add(0,1, 0, 0, 9,1, 1,1,  1,0,0, 8,1);          // cap relieved by retire
    for (int r = 2; r <= 9; r++) add(0,0, 0, 0, 0,0, 1,5'(r),  1,0,0, 9 - r, 0);
    for (int i = 1; i <= 3; i++) add(0,1, 0, 0, 7,1, 0,0,  1,0,0, i,0);
    add(0,1, 0, 0, 7,1, 0,0,  0,0,0, 3,0);          // WAW counter saturated
    add(0,1, 0, 0, 7,1, 1,7,  1,0,0, 3,0);          // inc+dec same reg
    add(0,1, 7, 0, 0,0, 1,7,  0,1,0, 2,0);          // pend>1: retire does not bypass
    add(0,0, 0, 0, 0,0, 1,7,  1,0,0, 1,0);
    add(0,1, 0, 7, 0,0, 1,7,  1,0,0, 0,0);
    for (int r = 1; r <= 4; r++) add(0,1, 0, 0, 5'(r),1, 0,0,  1,0,0, r,0);
    add(1,1, 1, 0,10,1, 0,0,  0,1,0, 0,0);          // flush drops state and issue
    add(0,1, 1, 2, 0,0, 0,0,  1,0,0, 0,0);

    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset inflight", 32'(inflight), 0);
    chk("reset full", 32'(full), 0);
    chk("reset ready", 32'(bus.issue_ready), 1);
    chk("reset stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;

    exp_stall = 0;
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      if (tbl[i].v && !tbl[i].rdy) exp_stall++;
    end
    drive_idle();
`ifdef SCOREBOARD_STATS_EN
    chk("stall after table", stall, 32'(exp_stall));
`else
    chk("stall tied off", stall, 0);
`endif

    // Asynchronous reset mid-cycle discards tracking without a clock edge.
    h = '{fl:0, v:1, rs1:0, rs2:0, rd:3, we:1, wv:0, wrd:0, rdy:1, b1:0, b2:0, cnt:1, full:0};
    apply(h, "pre_rst");
    drive_idle();
    #2 rst = 1'b1;
    #1;
    chk("async rst inflight", 32'(inflight), 0);
    chk("async rst stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;

    // Three stalled cycles, then flush leaves the stall count alone.
    h = '{fl:0, v:1, rs1:0, rs2:0, rd:6, we:1, wv:0, wrd:0, rdy:1, b1:0, b2:0, cnt:1, full:0};
    apply(h, "stall_w");
    h = '{fl:0, v:1, rs1:6, rs2:0, rd:0, we:0, wv:0, wrd:0, rdy:0, b1:1, b2:0, cnt:1, full:0};
    for (int i = 0; i < 3; i++) apply(h, $sformatf("stall%0d", i));
    h = '{fl:1, v:0, rs1:0, rs2:0, rd:0, we:0, wv:0, wrd:0, rdy:0, b1:0, b2:0, cnt:0, full:0};
    apply(h, "stall_flush");
    h = '{fl:0, v:1, rs1:6, rs2:6, rd:0, we:0, wv:0, wrd:0, rdy:1, b1:0, b2:0, cnt:0, full:0};
    apply(h, "post_flush");
    drive_idle();
`ifdef SCOREBOARD_STATS_EN
    chk("stall count kept", stall, 3);
`else
    chk("stall tied off end", stall, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/raw_hazard_scoreboard.md
Name: raw_hazard_scoreboard

Overview:
- Producer-side companion to operand forwarding: tracks every in-flight register write from issue until writeback retirement.
- Stalls issue when a source operand's producer has not yet retired and cannot be covered by a same-cycle writeback bypass.
- Sits between decode/issue and the execute pipeline. Also caps total in-flight writes.

Parameters:
- XLEN, 32, datapath width (from rapid_pkg; only used when stats are enabled).
- MAX_INFLIGHT, 8, maximum outstanding tracked writes across all registers (2..31).
- CNT_W, 2, width of the per-register pending counter; per-register limit is 2^CNT_W-1.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, asynchronous active-high reset.
- i_flush, input, 1, pipeline flush; clears all tracking.
- i_issue_valid, input, 1, instruction presented for issue.
- i_issue_rs1, input, 5, source 1 index.
- i_issue_rs2, input, 5, source 2 index.
- i_issue_rd, input, 5, destination index.
- i_issue_rd_we, input, 1, instruction writes rd.
- o_issue_ready, output, 1, issue may proceed this cycle.
- i_wb_valid, input, 1, a tracked write retires this cycle.
- i_wb_rd, input, 5, register retiring.
- o_rs1_busy, output, 1, rs1 has an outstanding un-bypassable producer.
- o_rs2_busy, output, 1, rs2 has an outstanding un-bypassable producer.
- o_inflight_cnt, output, $clog2(MAX_INFLIGHT+1), current outstanding writes.
- o_full, output, 1, o_inflight_cnt == MAX_INFLIGHT.
- o_stall_cycles, output, XLEN, stall counter (SCOREBOARD_STATS_EN only).

Behaviour:
- State: pend[1..31], each CNT_W bits, plus inflight counter. x0 is never tracked: pend[0] is hardwired 0, and issue or writeback with rd=0 is ignored.
- Reset (async, i_rst=1):
  - all pend=0, inflight=0;
  - o_full=0, o_inflight_cnt=0, o_rs1_busy=o_rs2_busy=0, o_stall_cycles=0;
  - o_issue_ready=1 whenever reset is deasserted and the state is clean.
  - Reset mid-operation discards all tracking immediately.
- Busy (combinational):
  - rsN_busy = (pend[rsN] > 1) OR (pend[rsN]==1 AND NOT (i_wb_valid AND i_wb_rd==rsN)).
  - A same-cycle retirement of the sole pending write counts as available, because forwarding covers it.
- Ready (combinational):
  - o_issue_ready = NOT rs1_busy AND NOT rs2_busy AND NOT waw_full AND NOT cap_full AND NOT i_flush.
  - waw_full: i_issue_rd_we, rd≠0, and pend[rd] == 2^CNT_W-1 with no same-cycle retire of rd.
  - cap_full: i_issue_rd_we, rd≠0, and inflight == MAX_INFLIGHT with no same-cycle retire.
- Busy output qualification: rs busy outputs are reported only while i_issue_valid=1, else 0. Ready is independent of i_issue_valid.
- Accept = i_issue_valid AND o_issue_ready.
- Update per clock:
  - inc = accept AND rd_we AND rd≠0; dec = i_wb_valid AND wb_rd≠0.
  - Same register incremented and decremented in one cycle: count unchanged. Otherwise each counter is adjusted independently.
  - inflight += inc − dec.
- Retire with pend[wb_rd]==0 is a protocol error: the counter holds at 0 (no underflow) and inflight does not decrement. Guard with a simulation-only assertion.
- Flush: on the next edge all pend=0 and inflight=0, and any issue or wb that cycle is ignored. The pipeline guarantees flushed instructions never assert i_wb_valid afterwards.
- Latency: ready and busy are zero-cycle combinational; state is visible the cycle after the edge.
- No registered outputs other than o_full, o_inflight_cnt and o_stall_cycles, which are derived from registers.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- Defined:
  - o_stall_cycles increments on every cycle with i_issue_valid=1 and o_issue_ready=0.
  - Saturates at all-ones.
  - Cleared by reset only; flush does not clear it.
- Undefined: o_stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then issue rd=5 (we=1) → next cycle o_inflight_cnt=1; issue rs1=5 → o_issue_ready=0 and o_rs1_busy=1.
- pend[5]=1, i_wb_valid=1 with wb_rd=5 in the same cycle as issue rs2=5 → o_issue_ready=1 (bypass), and inflight ends at 0.
- Issue rd=0 eight times → inflight stays 0 and ready is always 1; issue rs1=0 → never busy.
- Fill 8 writes to distinct rd (x1..x8) → o_full=1; ninth write rd=9 → ready=0; simultaneous wb rd=1 → ready=1 and inflight stays 8.
- Three writes to rd=7 (CNT_W=2) → fourth write to rd=7 stalls (waw_full); pend[7] stays 3 until a retire of rd=7.
- Populate 4 entries, assert i_flush → ready=0 that cycle; next cycle inflight=0, all busy=0. With SCOREBOARD_STATS_EN: a 3-cycle stall gives o_stall_cycles=3, unchanged after the flush.
